// File: rtl/exec_stage_if.sv
// Operand, control and result bundle between decode, the execute stage and memory.
// master: the side driving ops in and taking results; slave: the execute stage itself.
interface exec_stage_if #(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 3
);
    localparam int FS_W = $clog2(FWD_N + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [DATA_W-1:0]       A_data;
    logic [DATA_W-1:0]       B_data;
    logic [DATA_W-1:0]       S_data;
    logic [FWD_N*DATA_W-1:0] fwd_data;
    logic [FS_W-1:0]         sel_A_in;
    logic [FS_W-1:0]         sel_B_in;
    logic [FS_W-1:0]         sel_shift_in;
    logic                    sel_A;
    logic                    sel_B;
    logic [DATA_W-1:0]       imm;
    logic                    sel_shift;
    logic [7:0]              shift_imm;
    logic [1:0]              shift_op;
    logic [2:0]              ALU_op;
    logic                    en_status;
    logic                    sel_pre_indexed;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       datapath_out;
    logic [3:0]              status_out;
    logic                    busy;

    modport master (
        output in_valid, flush, A_data, B_data, S_data, fwd_data,
               sel_A_in, sel_B_in, sel_shift_in, sel_A, sel_B, imm,
               sel_shift, shift_imm, shift_op, ALU_op, en_status,
               sel_pre_indexed, out_ready,
        input  in_ready, out_valid, datapath_out, status_out, busy
    );

    modport slave (
        input  in_valid, flush, A_data, B_data, S_data, fwd_data,
               sel_A_in, sel_B_in, sel_shift_in, sel_A, sel_B, imm,
               sel_shift, shift_imm, shift_op, ALU_op, en_status,
               sel_pre_indexed, out_ready,
        output in_ready, out_valid, datapath_out, status_out, busy
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: forwarded operand latch, barrel shift, ALU, shift-add MUL when EXEC_MUL_EN is defined.
// Latency: 1 edge accept->out_valid (MUL: DATA_W+1 edges); back-to-back 1 op/cycle.
// Backpressure: result and flags frozen, in_ready low while out_valid && !out_ready.
module exec_stage #(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    exec_stage_if.slave  ex_if
);
    localparam int FS_W = $clog2(FWD_N + 1);
    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ORR = 3'd3;
    localparam logic [2:0] OP_EOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
`ifdef EXEC_MUL_EN
    localparam logic [2:0] OP_MUL = 3'd7;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef EXEC_MUL_EN
        S_MUL  = 2'd1,
`endif
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d, accept_state;

    logic [DATA_W-1:0] a_q, b_q, imm_q;
    logic [7:0]        amt_q;
    logic [1:0]        shift_op_q;
    logic [2:0]        alu_op_q;
    logic              sel_a_q, sel_b_q, en_status_q, pre_idx_q;
    logic [3:0]        flags_q, flags_d;

    function automatic logic [DATA_W-1:0] fwd_pick(input logic [DATA_W-1:0]       rf,
                                                   input logic [FS_W-1:0]         sel,
                                                   input logic [FWD_N*DATA_W-1:0] fwd);
        logic [DATA_W-1:0] v;
        v = rf;
        for (int k = 1; k <= FWD_N; k++) begin
            if (sel == FS_W'(k)) v = fwd[(k-1)*DATA_W +: DATA_W];
        end
        return v;
    endfunction

    logic [DATA_W-1:0] a_in, b_in, s_in;
    logic [7:0]        amt_in;
    logic              unused_s_hi;

    assign a_in        = fwd_pick(ex_if.A_data, ex_if.sel_A_in, ex_if.fwd_data);
    assign b_in        = fwd_pick(ex_if.B_data, ex_if.sel_B_in, ex_if.fwd_data);
    assign s_in        = fwd_pick(ex_if.S_data, ex_if.sel_shift_in, ex_if.fwd_data);
    assign amt_in      = ex_if.sel_shift ? s_in[7:0] : ex_if.shift_imm;
    assign unused_s_hi = ^s_in;

    logic in_ready, accept, retire;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE && ex_if.out_ready);
    assign accept   = ex_if.in_valid && in_ready && !ex_if.flush;
    assign retire   = (state_q == S_DONE) && ex_if.out_ready && !ex_if.flush;

`ifdef EXEC_MUL_EN
    assign accept_state = (ex_if.ALU_op == OP_MUL) ? S_MUL : S_DONE;
`else
    assign accept_state = S_DONE;
`endif

    // Barrel shifter; a right rotate by r is the OR of >>r and <<(-r mod DATA_W).
    logic [DATA_W-1:0] sh_b;
    logic [SH_W-1:0]   rot, rot_c;
    logic              big;

    always_comb begin
        big   = {24'd0, amt_q} >= 32'(DATA_W);
        rot   = SH_W'({24'd0, amt_q} % 32'(DATA_W));
        rot_c = ~rot + 1'b1;
        sh_b  = b_q;
        case (shift_op_q)
            2'b00:   sh_b = big ? '0 : (b_q << amt_q);
            2'b01:   sh_b = big ? '0 : (b_q >> amt_q);
            2'b10:   sh_b = big ? {DATA_W{b_q[MSB]}} : DATA_W'($signed(b_q) >>> amt_q);
            default: sh_b = (b_q >> rot) | (b_q << rot_c);
        endcase
    end

    logic [DATA_W-1:0] val_a, val_b, res;
    logic [DATA_W:0]   sum, dif;
    logic              c_new, v_new, flag_ok;

    assign val_a = sel_a_q ? '0 : a_q;
    assign val_b = sel_b_q ? imm_q : sh_b;
    assign sum   = {1'b0, val_a} + {1'b0, val_b};
    assign dif   = {1'b0, val_a} - {1'b0, val_b};

`ifdef EXEC_MUL_EN
    logic [DATA_W-1:0] mul_acc_q, mul_acc_d;
    logic [SH_W-1:0]   mul_cnt_q, mul_cnt_d;
`endif

    always_comb begin
        res     = '0;
        c_new   = flags_q[1];
        v_new   = flags_q[0];
        flag_ok = 1'b1;
        case (alu_op_q)
            OP_ADD: begin
                res   = sum[MSB:0];
                c_new = sum[DATA_W];
                v_new = (val_a[MSB] == val_b[MSB]) && (sum[MSB] != val_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                res   = dif[MSB:0];
                c_new = ~dif[DATA_W];
                v_new = (val_a[MSB] != val_b[MSB]) && (dif[MSB] != val_a[MSB]);
            end
            OP_AND:  res = val_a & val_b;
            OP_ORR:  res = val_a | val_b;
            OP_EOR:  res = val_a ^ val_b;
            OP_MOV:  res = val_b;
`ifdef EXEC_MUL_EN
            default: res = mul_acc_q;
`else
            default: flag_ok = 1'b0;
`endif
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (retire && en_status_q && flag_ok) begin
            flags_d = {res[MSB], (res == '0), c_new, v_new};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = accept_state;
`ifdef EXEC_MUL_EN
            S_MUL:  if (mul_cnt_q == SH_W'(DATA_W - 1)) state_d = S_DONE;
`endif
            S_DONE: if (ex_if.out_ready) state_d = accept ? accept_state : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ex_if.flush) state_d = S_IDLE;
    end

`ifdef EXEC_MUL_EN
    // One multiplier bit of val_b per cycle, LSB first.
    always_comb begin
        mul_acc_d = mul_acc_q;
        mul_cnt_d = mul_cnt_q;
        if (accept) begin
            mul_acc_d = '0;
            mul_cnt_d = '0;
        end else if (state_q == S_MUL) begin
            mul_acc_d = mul_acc_q + (val_b[mul_cnt_q] ? (val_a << mul_cnt_q) : '0);
            mul_cnt_d = mul_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_acc_q <= '0;
            mul_cnt_q <= '0;
        end else begin
            mul_acc_q <= mul_acc_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            flags_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            amt_q       <= '0;
            shift_op_q  <= '0;
            alu_op_q    <= '0;
            sel_a_q     <= 1'b0;
            sel_b_q     <= 1'b0;
            en_status_q <= 1'b0;
            pre_idx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            if (accept) begin
                a_q         <= a_in;
                b_q         <= b_in;
                imm_q       <= ex_if.imm;
                amt_q       <= amt_in;
                shift_op_q  <= ex_if.shift_op;
                alu_op_q    <= ex_if.ALU_op;
                sel_a_q     <= ex_if.sel_A;
                sel_b_q     <= ex_if.sel_B;
                en_status_q <= ex_if.en_status;
                pre_idx_q   <= ex_if.sel_pre_indexed;
            end
        end
    end

    assign ex_if.in_ready     = in_ready;
    assign ex_if.out_valid    = (state_q == S_DONE);
    assign ex_if.busy         = (state_q != S_IDLE);
    assign ex_if.datapath_out = pre_idx_q ? val_a : res;
    assign ex_if.status_out   = flags_q;
endmodule

// File: tb/tb_exec_stage.sv
// Randomised and directed bench for exec_stage against a transaction-level model of the stage.
module tb_exec_stage;
    localparam int DW = 32;
    localparam int FN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exec_stage_if #(.DATA_W(DW), .FWD_N(FN)) bus ();
    exec_stage #(.DATA_W(DW), .FWD_N(FN)) dut (.clk(clk), .rst_n(rst_n), .ex_if(bus));

    typedef struct {
        bit          in_valid, flush, out_ready;
        logic [31:0] a, b, s, imm;
        logic [95:0] fwd;
        logic [1:0]  sa, sb, ss;
        bit          sel_A, sel_B, sel_shift, en, pre;
        logic [7:0]  shift_imm;
        logic [1:0]  shift_op;
        logic [2:0]  op;
    } stim_t;

    typedef struct {
        logic [31:0] out, res;
        bit          c, v, upd, upd_cv, is_mul;
    } op_t;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_full;
    int          m_wait;
    op_t         m_op;
    logic [3:0]  m_flags;
    stim_t       st;
    logic [31:0] hold;
    int          nwait;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [31:0] rf, input logic [1:0] sel, input logic [95:0] fwd);
        int k;
        k = int'(sel);
        return (k == 0) ? rf : fwd[(k-1)*32 +: 32];
    endfunction

    function automatic op_t predict(input stim_t s);
        op_t         o;
        logic [31:0] va, braw, sh, vb, sv;
        logic [63:0] dbl, u, p;
        longint      sl;
        int          amt;
        o  = '{default: '0};
        va = s.sel_A ? 32'd0 : pick(s.a, s.sa, s.fwd);
        braw = pick(s.b, s.sb, s.fwd);
        sv = pick(s.s, s.ss, s.fwd);
        amt = s.sel_shift ? int'(sv[7:0]) : int'(s.shift_imm);
        dbl = {braw, braw};
        case (s.shift_op)
            2'd0: sh = (amt >= 32) ? 32'd0 : braw << amt;
            2'd1: sh = (amt >= 32) ? 32'd0 : braw >> amt;
            2'd2: sh = (amt >= 32) ? {32{braw[31]}} : 32'($signed(braw) >>> amt);
            default: sh = dbl[(amt % 32) +: 32];
        endcase
        vb = s.sel_B ? s.imm : sh;
        o.upd = s.en;
        case (s.op)
            3'd0: begin
                u = {32'd0, va} + {32'd0, vb};
                sl = longint'($signed(va)) + longint'($signed(vb));
                o.res = u[31:0]; o.c = u[32]; o.upd_cv = 1'b1;
                o.v = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
            end
            3'd1, 3'd6: begin
                sl = longint'($signed(va)) - longint'($signed(vb));
                o.res = va - vb; o.c = (va >= vb); o.upd_cv = 1'b1;
                o.v = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
            end
            3'd2: o.res = va & vb;
            3'd3: o.res = va | vb;
            3'd4: o.res = va ^ vb;
            3'd5: o.res = vb;
            default: begin
`ifdef EXEC_MUL_EN
                p = {32'd0, va} * {32'd0, vb};
                o.res = p[31:0];
                o.is_mul = 1'b1;
`else
                o.res = 32'd0;
                o.upd = 1'b0;
`endif
            end
        endcase
        o.out = s.pre ? va : o.res;
        return o;
    endfunction

    function automatic stim_t base_stim();
        stim_t s;
        s = '{default: '0};
        s.out_ready = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] edges [4];
        edges = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
        return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 32'($urandom);
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.in_valid  = ($urandom_range(0, 9) < 7);
        s.flush     = ($urandom_range(0, 19) == 0);
        s.out_ready = ($urandom_range(0, 9) < 7);
        s.a = rand_val(); s.b = rand_val(); s.s = 32'($urandom); s.imm = rand_val();
        s.fwd = {rand_val(), rand_val(), rand_val()};
        s.sa = 2'($urandom_range(0, 3)); s.sb = 2'($urandom_range(0, 3)); s.ss = 2'($urandom_range(0, 3));
        s.sel_A = ($urandom_range(0, 7) == 0);
        s.sel_B = ($urandom_range(0, 2) == 0);
        s.sel_shift = ($urandom_range(0, 3) == 0);
        s.en = ($urandom_range(0, 1) == 1);
        s.pre = ($urandom_range(0, 7) == 0);
        s.shift_imm = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
        s.shift_op = 2'($urandom_range(0, 3));
        s.op = 3'($urandom_range(0, 7));
        if (s.op == 3'd7 && $urandom_range(0, 3) != 0) s.op = 3'd0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.in_valid = s.in_valid; bus.flush = s.flush; bus.out_ready = s.out_ready;
        bus.A_data = s.a; bus.B_data = s.b; bus.S_data = s.s; bus.imm = s.imm; bus.fwd_data = s.fwd;
        bus.sel_A_in = s.sa; bus.sel_B_in = s.sb; bus.sel_shift_in = s.ss;
        bus.sel_A = s.sel_A; bus.sel_B = s.sel_B; bus.sel_shift = s.sel_shift;
        bus.shift_imm = s.shift_imm; bus.shift_op = s.shift_op; bus.ALU_op = s.op;
        bus.en_status = s.en; bus.sel_pre_indexed = s.pre;
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_wait = 0; m_flags = 4'h0; m_op = '{default: '0};
    endtask

    task automatic model_edge(input stim_t s, input bit ev, input bit er);
        bit ret;
        if (s.flush) begin
            m_full = 1'b0;
        end else begin
            ret = ev && s.out_ready;
            if (ret && m_op.upd) begin
                m_flags[3] = m_op.res[31];
                m_flags[2] = (m_op.res == 32'd0);
                if (m_op.upd_cv) m_flags[1:0] = {m_op.c, m_op.v};
            end
            if (s.in_valid && er) begin
                m_op = predict(s);
                m_full = 1'b1;
                m_wait = m_op.is_mul ? 32 : 0;
            end else if (ret) begin
                m_full = 1'b0;
            end else if (m_full && m_wait > 0) begin
                m_wait--;
            end
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, clock, advance model.
    task automatic step();
        bit ev, er;
        apply(st);
        #1;
        ev = m_full && (m_wait == 0);
        er = !m_full || ((m_wait == 0) && st.out_ready);
        check_eq("in_ready", bus.in_ready, er);
        check_eq("out_valid", bus.out_valid, ev);
        check_eq("busy", bus.busy, m_full);
        check_eq("status", bus.status_out, m_flags);
        if (ev) check_eq("datapath", bus.datapath_out, m_op.out);
        @(posedge clk);
        model_edge(st, ev, er);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1'b1);
        check_eq({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_data"}, bus.datapath_out, 32'd0);
        check_eq({tag, "_status"}, bus.status_out, 4'h0);
    endtask

    initial begin
        st = base_stim();
        apply(st);
        model_reset();
        #1;
        check_reset_outputs("rst0");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // ADD overflow into the sign bit
        st = base_stim(); st.in_valid = 1; st.a = 32'h7FFF_FFFF; st.sel_B = 1; st.imm = 32'd1; st.op = 3'd0; st.en = 1;
        step();
        check_eq("add_out", bus.datapath_out, 32'h8000_0000);
        st.in_valid = 0; step();
        check_eq("add_flags", bus.status_out, 4'b1001);

        // SUB with A from forward source 2
        st = base_stim(); st.in_valid = 1; st.a = 32'd9; st.fwd = {32'd0, 32'd5, 32'd0}; st.sa = 2'd2;
        st.sel_B = 1; st.imm = 32'd5; st.op = 3'd1; st.en = 1;
        step();
        check_eq("sub_out", bus.datapath_out, 32'd0);
        st.in_valid = 0; step();
        check_eq("sub_flags", bus.status_out, 4'b0110);

        // Shift boundaries, issued back to back
        st = base_stim(); st.in_valid = 1; st.sel_A = 1; st.op = 3'd5; st.b = 32'h8000_0000;
        st.shift_op = 2'd2; st.shift_imm = 8'd40;
        step();
        check_eq("asr40", bus.datapath_out, 32'hFFFF_FFFF);
        st.shift_op = 2'd1; st.shift_imm = 8'd32;
        step();
        check_eq("lsr32", bus.datapath_out, 32'd0);
        st.b = 32'd1; st.shift_op = 2'd3; st.shift_imm = 8'd36;
        step();
        check_eq("ror36", bus.datapath_out, 32'h1000_0000);
        st.in_valid = 0; step();

        // MUL with new ops offered throughout
        st = base_stim(); st.in_valid = 1; st.a = 32'h1234; st.sel_B = 1; st.imm = 32'h10; st.op = 3'd7;
        step();
        st.op = 3'd0;
`ifdef EXEC_MUL_EN
        repeat (31) step();
        check_eq("mul_wait_vld", bus.out_valid, 1'b0);
        check_eq("mul_wait_busy", bus.busy, 1'b1);
        step();
        check_eq("mul_out", bus.datapath_out, 32'h12340);
`else
        check_eq("mul_out", bus.datapath_out, 32'd0);
`endif
        check_eq("mul_vld", bus.out_valid, 1'b1);
        st = base_stim(); step();

        // Backpressure for three cycles, then retire+accept on one edge
        st = base_stim(); st.in_valid = 1; st.a = 32'hF000_0000; st.sel_B = 1; st.imm = 32'd0; st.op = 3'd4; st.en = 1;
        step();
        hold = bus.datapath_out;
        st.out_ready = 0; st.a = 32'd1; st.imm = 32'd1; st.op = 3'd0; st.en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_hold", bus.datapath_out, hold);
        end
        st.out_ready = 1; step();
        check_eq("bp_flags", bus.status_out, 4'b1010);
        check_eq("bp_next", bus.datapath_out, 32'd2);
        st = base_stim(); step();

        // Flush an in-flight op (mid-MUL when the multiplier exists)
        st = base_stim(); st.in_valid = 1; st.a = 32'd5; st.sel_B = 1; st.imm = 32'd7; st.op = 3'd7; st.en = 1;
        step();
        st.in_valid = 0;
`ifdef EXEC_MUL_EN
        nwait = 9;
`else
        nwait = 0;
`endif
        for (int i = 0; i < nwait; i++) step();
        st.flush = 1; st.in_valid = 1; step();
        check_eq("flush_vld", bus.out_valid, 1'b0);
        check_eq("flush_busy", bus.busy, 1'b0);
        check_eq("flush_flags", bus.status_out, 4'b1010);
        st = base_stim(); step();

        // Asynchronous reset while holding a result
        st = base_stim(); st.in_valid = 1; st.a = 32'd1; st.sel_B = 1; st.op = 3'd3; st.en = 1;
        step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 1200; i++) begin
            st = rand_stim();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
